// File: rtl/dht11_pkg.sv
// Shared types and timing helpers for the DHT11 single-wire receiver.
package dht11_pkg;

  localparam int unsigned FRAME_W = 40;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned us);
    return 32'((clk_hz * us) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the DHT11 bus with rise/fall detection on the synchronized level.
module dht11_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic level;
  logic prev;

  // Bus idles high, so reset to 1 to avoid a false falling edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/dht11_rx.sv
// DHT11 frame receiver: issues the host start pulse, times the sensor response and decodes 40 bits.
module dht11_rx
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned START_US   = 18_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned THRESH_US  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  inout  wire        data,
  output logic       en_set,
  output logic       busy,
  output logic [7:0] hum,
  output logic [7:0] temp,
  output logic       valid,
  output logic       err
);

  localparam int unsigned START_CYC   = us_to_cycles(64'(CLK_HZ), 64'(START_US));
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(64'(CLK_HZ), 64'(TIMEOUT_US));
  localparam int unsigned THRESH_CYC  = us_to_cycles(64'(CLK_HZ), 64'(THRESH_US));
  localparam int unsigned CNT_MAX     = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W       = $clog2(FRAME_W + 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bits, bits_n;
  logic [FRAME_W-1:0]   shreg, shreg_n;
  logic                 busy_n, en_set_n, valid_n, err_n;
  logic [7:0]           hum_n, temp_n;
  logic                 rise_c, fall_c;
  logic                 bit_val_c;
  logic                 timeout_c;
  logic [7:0]           sum_c;

  dht11_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (data),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign data = en_set ? 1'bz : (state != START_LOW);

  // Count is sampled in the falling-edge cycle, so cnt+1 cycles of high time were seen.
  assign bit_val_c = 32'(cnt) >= THRESH_CYC;
  assign timeout_c = (state inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH}) &&
                     (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign sum_c     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bits   <= '0;
      shreg  <= '0;
      busy   <= 1'b0;
      en_set <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
      hum    <= '0;
      temp   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bits   <= bits_n;
      shreg  <= shreg_n;
      busy   <= busy_n;
      en_set <= en_set_n;
      valid  <= valid_n;
      err    <= err_n;
      hum    <= hum_n;
      temp   <= temp_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (state == IDLE) ? '0 : cnt + CNT_W'(1);
    bits_n   = bits;
    shreg_n  = shreg;
    busy_n   = busy;
    en_set_n = en_set;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    hum_n    = hum;
    temp_n   = temp;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = START_LOW;
          bits_n  = '0;
          busy_n  = 1'b1;
        end
      end
      START_LOW: begin
        if (cnt == CNT_W'(START_CYC - 1)) begin
          state_n  = WAIT_RESP;
          en_set_n = 1'b1;
        end
      end
      WAIT_RESP: if (fall_c) state_n = RESP_LOW;
      RESP_LOW:  if (rise_c) state_n = RESP_HIGH;
      RESP_HIGH: if (fall_c) state_n = BIT_LOW;
      BIT_LOW:   if (rise_c) state_n = BIT_HIGH;
      BIT_HIGH: begin
        if (fall_c) begin
          shreg_n = {shreg[FRAME_W-2:0], bit_val_c};
          bits_n  = bits + BIT_W'(1);
          state_n = (bits == BIT_W'(FRAME_W - 1)) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        state_n  = IDLE;
        busy_n   = 1'b0;
        en_set_n = 1'b0;
        if (sum_c == shreg[7:0]) begin
          valid_n = 1'b1;
          hum_n   = shreg[39:32];
          temp_n  = shreg[23:16];
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // An edge arriving in the same cycle wins over the timeout.
    if (timeout_c && (state_n == state)) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      en_set_n = 1'b0;
      err_n    = 1'b1;
    end

    if (state_n != state) cnt_n = '0;
  end

endmodule

// File: tb/tb_dht11_rx.sv
// Directed bench for dht11_rx with a simple open-drain DHT11 sensor model (1 cycle = 1 us).
module tb_dht11_rx;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned START_US   = 100;
  localparam int unsigned TIMEOUT_US = 200;
  localparam int unsigned THRESH_US  = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  wire        data;
  logic       en_set, busy, valid, err;
  logic [7:0] hum, temp;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0, n;

  pullup (data);
  assign data = sensor_low ? 1'b0 : 1'bz;

  dht11_rx #(
    .CLK_HZ     (CLK_HZ),
    .START_US   (START_US),
    .TIMEOUT_US (TIMEOUT_US),
    .THRESH_US  (THRESH_US)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .en_set (en_set),
    .busy   (busy),
    .hum    (hum),
    .temp   (temp),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid) valid_cnt <= valid_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (valid && err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int k;
    k = 0;
    while (!en_set && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(en_set), 32'd1);
  endtask

  task automatic hold(input logic low, input int cycles);
    sensor_low = low;
    repeat (cycles) @(negedge clk);
  endtask

  // Response then nbits bits; a partial frame returns with the line held low.
  task automatic sensor_frame(input logic [39:0] f, input int h0, input int h1, input int nbits);
    hold(1'b0, 20);
    hold(1'b1, 80);
    hold(1'b0, 80);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b1, 50);
      hold(1'b0, f[39-i] ? h1 : h0);
    end
    if (nbits == 40) begin
      hold(1'b1, 2);
      sensor_low = 1'b0;
    end else begin
      sensor_low = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [39:0] f, input int h0, input int h1, input string tag);
    pulse_start();
    wait_en(tag);
    sensor_frame(f, h0, h1, 40);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en_set", 32'(en_set), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_hum",    32'(hum),    32'd0);
    check("rst_temp",   32'(temp),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_data_high", 32'(data), 32'd1);

    // Frame A with a second start during START_LOW
    v0 = valid_cnt; e0 = err_cnt;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_low_data", 32'(data), 32'd0);
    n = 0;
    while (!en_set && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
    end
    check("start_low_len", 32'(n), 32'd100);
    check("release_busy", 32'(busy), 32'd1);
    sensor_frame({8'd52, 8'd0, 8'd24, 8'd0, 8'd76}, 27, 75, 40);
    repeat (10) @(negedge clk);
    check("a_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a_err_cnt",   32'(err_cnt - e0),   32'd0);
    check("a_hum",       32'(hum),  32'h34);
    check("a_temp",      32'(temp), 32'h18);
    check("a_busy",      32'(busy), 32'd0);
    check("a_en_set",    32'(en_set), 32'd0);
    repeat (200) @(negedge clk);
    check("a_no_restart", 32'(busy), 32'd0);

    // Frame B: bad checksum
    v0 = valid_cnt; e0 = err_cnt;
    run_frame({8'd52, 8'd0, 8'd24, 8'd0, 8'd77}, 27, 75, "b_en");
    check("b_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("b_err_cnt",   32'(err_cnt - e0),   32'd1);
    check("b_hum",       32'(hum),  32'h34);
    check("b_temp",      32'(temp), 32'h18);

    // Frame C: bad checksum with different payload must not load
    v0 = valid_cnt; e0 = err_cnt;
    run_frame({8'd60, 8'd0, 8'd30, 8'd0, 8'd91}, 27, 75, "c_en");
    check("c_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("c_hum",     32'(hum),  32'h34);
    check("c_temp",    32'(temp), 32'h18);

    // Frame D: 49/51 us threshold bits, nonzero b1/b3, checksum wraps (321 mod 256)
    v0 = valid_cnt; e0 = err_cnt;
    run_frame({8'hC8, 8'h10, 8'h64, 8'h05, 8'h41}, 49, 51, "d_en");
    check("d_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("d_err_cnt",   32'(err_cnt - e0),   32'd0);
    check("d_hum",       32'(hum),  32'hC8);
    check("d_temp",      32'(temp), 32'h64);

    // Silent sensor: timeout after release
    v0 = valid_cnt; e0 = err_cnt;
    pulse_start();
    wait_en("to_en");
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'd200);
    check("to_en_set", 32'(en_set), 32'd0);
    check("to_busy",   32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("to_err_cnt",   32'(err_cnt - e0), 32'd1);
    check("to_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("to_hum",       32'(hum), 32'hC8);

    // Reset after bit 20
    v0 = valid_cnt; e0 = err_cnt;
    pulse_start();
    wait_en("r_en");
    sensor_frame({8'd52, 8'd0, 8'd24, 8'd0, 8'd76}, 27, 75, 20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sensor_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("r_en_set", 32'(en_set), 32'd0);
    check("r_busy",   32'(busy), 32'd0);
    check("r_hum",    32'(hum), 32'd0);
    repeat (300) @(negedge clk);
    check("r_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("r_err_cnt",   32'(err_cnt - e0),   32'd0);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame({8'd52, 8'd0, 8'd24, 8'd0, 8'd76}, 27, 75, "r2_en");
    check("r2_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("r2_hum",       32'(hum),  32'h34);
    check("r2_temp",      32'(temp), 32'h18);

    check("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dht11_rx.md
DHT11_RX -- requirements
Module: dht11_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency used to derive all microsecond timings.
REQ-002 Parameter START_US, default 18_000, host start-pulse low time.
REQ-003 Parameter TIMEOUT_US, default 200, maximum duration of any single sensor phase.
REQ-004 Parameter THRESH_US, default 50, bit high-time threshold; high time > THRESH_US decodes as 1.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to read one frame.
REQ-008 data  inout  1  DHT11 single-wire bus.
REQ-009 en_set  output  1  1 = host has released data and the sensor owns the line; 0 = host drives data.
REQ-010 busy  output  1  high from the accepted start until the valid or err pulse.
REQ-011 hum  output  8  humidity integer byte of the last good frame.
REQ-012 temp  output  8  temperature integer byte of the last good frame.
REQ-013 valid  output  1  one-cycle pulse when a frame passes its checksum.
REQ-014 err  output  1  one-cycle pulse on checksum fail or timeout.

Function
REQ-015 data SHALL be driven 0 in START_LOW and 1 in the other host-owned states, and SHALL be high-Z while en_set=1.
REQ-016 The sampled bus SHALL pass through a 2-FF synchronizer; all edge and level decisions use the synchronized value (2-cycle latency).
REQ-017 FSM states: IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-018 IDLE: when start=1, go to START_LOW, clear the phase counter and bit counter, and set busy.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 START_LOW: after START_US*CLK_HZ/1e6 cycles, go to WAIT_RESP and set en_set=1.
REQ-021 WAIT_RESP: on a synchronized falling edge, go to RESP_LOW.
REQ-022 RESP_LOW: on a rising edge, go to RESP_HIGH.
REQ-023 RESP_HIGH: on a falling edge, go to BIT_LOW.
REQ-024 BIT_LOW: on a rising edge, go to BIT_HIGH and clear the phase counter.
REQ-025 BIT_HIGH: on a falling edge, shift in (count > THRESH cycles) MSB-first into a 40-bit register and increment the bit counter.
REQ-026 After the falling edge that completes the 40th bit, go to CHECK; otherwise return to BIT_LOW.
REQ-027 The phase counter SHALL reset on every state change; if it reaches the TIMEOUT cycle count in any of WAIT_RESP through BIT_HIGH, the FSM goes to IDLE and pulses err.
REQ-028 CHECK: checksum = (b0+b1+b2+b3) mod 256, 8-bit wrap.
REQ-029 CHECK, match: load hum=b0, temp=b2, and pulse valid.
REQ-030 CHECK, mismatch: pulse err with hum/temp unchanged.
REQ-031 CHECK SHALL in either case return to IDLE in the next cycle.
REQ-032 Leaving the sensor-owned states SHALL clear en_set and busy in the same cycle as the valid/err pulse.
REQ-033 valid and err SHALL never be high in the same cycle.
REQ-034 Bytes b1 and b3 are used only in the checksum.

Reset
REQ-035 rst=1 at any time, including mid-frame, SHALL force IDLE on the next edge.
REQ-036 Reset values: en_set=0, busy=0, valid=0, err=0, hum=0, temp=0, with all counters and the shift register cleared.
REQ-037 A partial frame interrupted by reset SHALL produce no valid or err pulse.

Structure
REQ-038 Package dht11_pkg SHALL hold: the state enum, a us-to-cycles constant function, and the frame width (40).
REQ-039 Sub-module dht11_sync SHALL provide the 2-FF synchronizer plus rise/fall edge detect; all other logic lives in dht11_rx.

Verification
REQ-040 Frame hum=52, temp=24, zero bytes, checksum=76 -> one valid pulse, hum=8'h34, temp=8'h18, err=0.
REQ-041 Same frame with checksum=77 -> one err pulse, hum/temp keep their prior values.
REQ-042 Sensor silent (line stays high after release) -> err exactly TIMEOUT_US after en_set rises, and en_set=0 in the same cycle.
REQ-043 Bit high times of 27us and 75us -> decoded 0 and 1; 49us -> 0; 51us -> 1.
REQ-044 rst asserted after bit 20 -> IDLE next cycle, no pulses, en_set=0; a new start then reads the next frame correctly.
REQ-045 start pulsed again during START_LOW -> ignored, and exactly one valid pulse per frame.
